// File: rtl/cdr_pkg.sv
// cdr_pkg: shared CDR types, default gains and widths, and phase-detector error decode
package cdr_pkg;
  typedef enum logic {ACQ, TRK} loop_state_t;
  typedef logic signed [1:0] err_t;
  localparam int FCW_W_DEF      = 10;
  localparam int FCW_CENTER_DEF = 512;
  localparam int INT_W_DEF      = 16;
  localparam int INT_FRAC_DEF   = 4;
  localparam int KI_DEF         = 1;
  localparam int KP_ACQ_DEF     = 16;
  localparam int KP_TRK_DEF     = 4;
  localparam int RUN_MAX_DEF    = 8;
  localparam int LOCK_CNT_DEF   = 64;
  function automatic err_t pd_err(input logic up, input logic dn);
    return (up && !dn) ? 2'sd1 : (dn && !up) ? -2'sd1 : 2'sd0;
  endfunction
endpackage

// File: rtl/cdr_loop_filter_if.sv
// cdr_loop_filter_if: phase-detector input and DCO control output bundle of the loop filter
interface cdr_loop_filter_if #(parameter int FCW_W = cdr_pkg::FCW_W_DEF);
  logic             freeze;
  logic             pd_valid;
  logic             pd_up;
  logic             pd_dn;
  logic [FCW_W-1:0] fcw;
  logic             fcw_valid;
  logic             locked;
  logic             int_sat;
  modport master (output freeze, pd_valid, pd_up, pd_dn, input fcw, fcw_valid, locked, int_sat);
  modport slave  (input freeze, pd_valid, pd_up, pd_dn, output fcw, fcw_valid, locked, int_sat);
endinterface

// File: rtl/cdr_lock_det.sv
// cdr_lock_det: same-sign run counter, good-sample counter and ACQ/TRK gear FSM
module cdr_lock_det import cdr_pkg::*; #(
  parameter int RUN_MAX  = RUN_MAX_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc,
  input  err_t        err,
  output logic        locked,
  output loop_state_t gain_sel
);
  localparam int RW = $clog2(RUN_MAX + 2);
  localparam int GW = $clog2(LOCK_CNT + 1);
  logic [RW-1:0] run_q, run_d;
  logic [GW-1:0] good_q, good_d;
  logic          neg_q, neg_d;
  loop_state_t   state_q, state_d;
  always_comb begin
    neg_d   = neg_q;
    run_d   = run_q;
    good_d  = good_q;
    state_d = state_q;
    if (acc) begin
      if (err != 2'sd0) begin
        neg_d = err[1];
        run_d = (run_q == '0 || err[1] != neg_q) ? RW'(1) :
                run_q == RW'(RUN_MAX + 1) ? run_q : run_q + RW'(1);
      end
      good_d  = run_d > RW'(RUN_MAX) ? '0 : good_q == GW'(LOCK_CNT) ? good_q : good_q + GW'(1);
      state_d = run_d > RW'(RUN_MAX) ? ACQ : good_d == GW'(LOCK_CNT) ? TRK : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q   <= '0;
      good_q  <= '0;
      neg_q   <= 1'b0;
      state_q <= ACQ;
    end else begin
      run_q   <= run_d;
      good_q  <= good_d;
      neg_q   <= neg_d;
      state_q <= state_d;
    end
  end
  assign locked   = state_q == TRK;
  assign gain_sel = state_q;
endmodule

// File: rtl/cdr_loop_filter.sv
// cdr_loop_filter: bang-bang PI loop filter with gear shifting, producing the DCO frequency control word
module cdr_loop_filter import cdr_pkg::*; #(
  parameter int FCW_W      = FCW_W_DEF,
  parameter int FCW_CENTER = FCW_CENTER_DEF,
  parameter int INT_W      = INT_W_DEF,
  parameter int INT_FRAC   = INT_FRAC_DEF,
  parameter int KI         = KI_DEF,
  parameter int KP_ACQ     = KP_ACQ_DEF,
  parameter int KP_TRK     = KP_TRK_DEF,
  parameter int RUN_MAX    = RUN_MAX_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF
) (
  input logic              clk,
  input logic              rst_n,
  cdr_loop_filter_if.slave bus
);
  localparam int SW = INT_W + 2;
  localparam logic signed [INT_W:0]  IMAX = (INT_W+1)'(2**(INT_W-1) - 1);
  localparam logic signed [INT_W:0]  IMIN = -IMAX;
  localparam logic signed [INT_W:0]  KI_S = (INT_W+1)'(KI);
  localparam logic signed [SW-1:0]   FMAX = SW'(2**FCW_W - 1);
  localparam logic signed [SW-1:0]   CTR  = SW'(FCW_CENTER);
  logic                    acc;
  err_t                    err, err_q, err_d;
  logic signed [INT_W:0]   int_sum;
  logic signed [INT_W-1:0] int_q, int_d;
  logic signed [SW-1:0]    kp_q, kp_d, sum;
  logic                    v_q, v_d, fcw_valid_q, fcw_valid_d;
  logic [FCW_W-1:0]        fcw_q, fcw_d;
  loop_state_t             gain_sel;
  logic                    locked;
  always_comb begin
    acc         = bus.pd_valid && !bus.freeze;
    err         = acc ? pd_err(bus.pd_up, bus.pd_dn) : 2'sd0;
    int_sum     = $signed({int_q[INT_W-1], int_q}) + (err == 2'sd1 ? KI_S : err == -2'sd1 ? -KI_S : '0);
    int_d       = !acc ? int_q : int_sum > IMAX ? IMAX[INT_W-1:0] :
                  int_sum < IMIN ? IMIN[INT_W-1:0] : int_sum[INT_W-1:0];
    err_d       = err;
    v_d         = acc;
    kp_d        = gain_sel == TRK ? SW'(KP_TRK) : SW'(KP_ACQ);
    // second stage sees the already-updated integrator
    sum         = CTR + SW'(int_q >>> INT_FRAC) + (err_q == 2'sd1 ? kp_q : err_q == -2'sd1 ? -kp_q : '0);
    fcw_d       = !v_q ? fcw_q : sum[SW-1] ? '0 : sum > FMAX ? '1 : sum[FCW_W-1:0];
    fcw_valid_d = v_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_q       <= '0;
      err_q       <= 2'sd0;
      kp_q        <= '0;
      v_q         <= 1'b0;
      fcw_q       <= FCW_W'(FCW_CENTER);
      fcw_valid_q <= 1'b0;
    end else begin
      int_q       <= int_d;
      err_q       <= err_d;
      kp_q        <= kp_d;
      v_q         <= v_d;
      fcw_q       <= fcw_d;
      fcw_valid_q <= fcw_valid_d;
    end
  end
  cdr_lock_det #(.RUN_MAX(RUN_MAX), .LOCK_CNT(LOCK_CNT)) u_lock (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc      (acc),
    .err      (err),
    .locked   (locked),
    .gain_sel (gain_sel)
  );
  assign bus.fcw       = fcw_q;
  assign bus.fcw_valid = fcw_valid_q;
  assign bus.locked    = locked;
  assign bus.int_sat   = int_q == IMAX[INT_W-1:0] || int_q == IMIN[INT_W-1:0];
endmodule

// File: tb/tb_cdr_loop_filter.sv
// tb_cdr_loop_filter: directed vectors for the loop filter, default gains and a KI=4096 saturation instance
module tb_cdr_loop_filter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vcnt = 0;
  int   v0;
  cdr_loop_filter_if #(.FCW_W(10)) bus0 ();
  cdr_loop_filter_if #(.FCW_W(10)) bus1 ();
  cdr_loop_filter u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cdr_loop_filter #(.KI(4096)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #10 clk = ~clk;
  always @(negedge clk) if (bus0.fcw_valid) vcnt++;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pd(input bit s, input logic v, input logic u, input logic d);
    bus0.pd_valid = v && !s;
    bus0.pd_up    = u && !s;
    bus0.pd_dn    = d && !s;
    bus1.pd_valid = v && s;
    bus1.pd_up    = u && s;
    bus1.pd_dn    = d && s;
    tick();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask
  initial begin
    bus0.freeze = 1'b0;
    bus1.freeze = 1'b0;
    pd(0, 0, 0, 0);
    do_reset();
    chk("rst_fcw", bus0.fcw, 512);
    chk("rst_locked", bus0.locked, 0);
    chk("rst_fcw_valid", bus0.fcw_valid, 0);
    chk("rst_int_sat", bus0.int_sat, 0);
    vcnt = 0;
    pd(0, 1, 1, 0);
    pd(0, 0, 0, 0);
    chk("up1_fcw", bus0.fcw, 528);
    chk("up1_valid", bus0.fcw_valid, 1);
    for (int i = 0; i < 15; i++) pd(0, 1, 1, 0);
    pd(0, 0, 0, 0);
    chk("up16_fcw", bus0.fcw, 529);
    chk("up16_locked", bus0.locked, 0);
    tick();
    chk("up16_valid_cnt", vcnt, 16);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      pd(0, 1, i % 2 == 0, i % 2 == 1);
      if (i == 62) chk("alt63_locked", bus0.locked, 0);
    end
    chk("alt64_locked", bus0.locked, 1);
    pd(0, 1, 1, 0);
    pd(0, 0, 0, 0);
    chk("trk_up_fcw", bus0.fcw, 516);
    chk("trk_up_locked", bus0.locked, 1);
    for (int i = 0; i < 7; i++) pd(0, 1, 1, 0);
    chk("run8_locked", bus0.locked, 1);
    pd(0, 1, 1, 0);
    pd(0, 1, 1, 0);
    chk("run10_locked", bus0.locked, 0);
    pd(0, 0, 0, 0);
    vcnt = 0;
    pd(0, 1, 1, 1);
    pd(0, 0, 0, 0);
    chk("null_fcw", bus0.fcw, 512);
    chk("null_valid", bus0.fcw_valid, 1);
    pd(0, 1, 1, 0);
    pd(0, 0, 0, 0);
    chk("acq_gain_fcw", bus0.fcw, 528);
    chk("acq_int_sat", bus0.int_sat, 0);
    tick();
    v0 = vcnt;
    bus0.freeze = 1'b1;
    for (int i = 0; i < 10; i++) pd(0, 1, 1, 0);
    pd(0, 0, 0, 0);
    tick();
    chk("frz_fcw", bus0.fcw, 528);
    chk("frz_valid_cnt", vcnt - v0, 0);
    chk("frz_locked", bus0.locked, 0);
    bus0.freeze = 1'b0;
    pd(0, 1, 1, 0);
    rst_n = 1'b0;
    tick();
    chk("midrst_fcw", bus0.fcw, 512);
    chk("midrst_valid", bus0.fcw_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_valid_cnt", vcnt - v0, 0);
    do_reset();
    for (int i = 0; i < 7; i++) pd(1, 1, 1, 0);
    chk("sat7_int_sat", bus1.int_sat, 0);
    pd(1, 1, 1, 0);
    chk("sat8_int_sat", bus1.int_sat, 1);
    pd(1, 0, 0, 0);
    chk("sat8_fcw", bus1.fcw, 1023);
    pd(1, 1, 0, 1);
    chk("satdn_int_sat", bus1.int_sat, 0);
    pd(1, 0, 0, 0);
    chk("satdn_fcw", bus1.fcw, 1023);
    for (int i = 0; i < 16; i++) pd(1, 1, 0, 1);
    pd(1, 0, 0, 0);
    chk("negsat_int_sat", bus1.int_sat, 1);
    chk("negsat_fcw", bus1.fcw, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cdr_loop_filter.md
# cdr_loop_filter

Digital proportional-integral loop filter with gear-shifting and lock detection for the all-digital CDR/ADPLL. It consumes early/late decisions from the bang-bang phase detector and produces the frequency control word (FCW) that drives the DCO. It sits between the phase detector and the DCO inside `tt_um_adpll`. It runs on the 50 MHz system clock.

## Interface
Parameters:
- `FCW_W`, 10, FCW width (unsigned).
- `FCW_CENTER`, 512, FCW at reset and with a zero integrator.
- `INT_W`, 16, integrator width (signed).
- `INT_FRAC`, 4, fractional bits of the integrator; FCW uses `int_acc >>> INT_FRAC`.
- `KI`, 1, integral gain (integer step per error).
- `KP_ACQ`, 16, proportional gain in ACQ.
- `KP_TRK`, 4, proportional gain in TRK.
- `RUN_MAX`, 8, maximum allowed run of same-sign errors.
- `LOCK_CNT`, 64, consecutive good samples required to lock.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `freeze`  in  1  hold the loop and ignore the PD.
- `pd_valid`  in  1  single-cycle strobe; `pd_up`/`pd_dn` are valid.
- `pd_up`  in  1  late decision (raise frequency).
- `pd_dn`  in  1  early decision (lower frequency).
- `fcw`  out  FCW_W  frequency control word to the DCO.
- `fcw_valid`  out  1  one-cycle pulse when `fcw` has been updated.
- `locked`  out  1  lock indicator.
- `int_sat`  out  1  integrator is at a saturation rail.

## Operation
- **Error decode** (when `pd_valid && !freeze`):
  - `err = +1` for up only.
  - `err = -1` for dn only.
  - `err = 0` when both or neither are set.
- **Integrator:**
  - `int_acc += err*KI`, computed at INT_W+1 bits.
  - Saturates to ±(2^(INT_W-1)-1).
  - `int_sat` is high whenever `int_acc` sits at a rail.
- **FCW:**
  - `FCW_CENTER + (int_acc >>> INT_FRAC) + err*KP` is summed at INT_W+2 signed bits.
  - The result clamps to [0, 2^FCW_W-1].
  - `KP` is `KP_ACQ` in state ACQ and `KP_TRK` in state TRK.
  - The calculation uses the updated `int_acc`.
- **Run counter:**
  - Tracks the sign of the last nonzero error.
  - Same sign: increment, saturating at RUN_MAX+1.
  - Sign change, or first nonzero error: load 1.
  - `err = 0`: unchanged.
- **Good counter:**
  - Increments on every accepted sample, saturating at LOCK_CNT.
  - Clears when run > RUN_MAX.
- **State machine** (2 states; `locked` = state==TRK):
  - ACQ→TRK when the good counter reaches LOCK_CNT.
  - TRK→ACQ on the first sample where run > RUN_MAX; the good counter is cleared at the same time.
  - The new gain applies from the next accepted sample.
- **`freeze` high:**
  - Samples are discarded.
  - No integrator, run, good-counter or state update.
  - `fcw` holds and `fcw_valid` stays 0.
  - `freeze` takes priority over `pd_valid` in the same cycle.
- **Reset values:**
  - `fcw = FCW_CENTER`; `int_acc = 0`.
  - run = 0, good = 0, state ACQ.
  - `fcw_valid = 0`, `locked = 0`, `int_sat = 0`.
  - Reset mid-operation discards any in-flight sample.

## Timing
- Two-stage pipeline:
  - Edge E samples the PD. It updates `int_acc`, the run and good counters and the state, and registers `err_q` and `kp_q`.
  - Edge E+1 registers `fcw` and pulses `fcw_valid`.
- `locked` changes at edge E, one cycle before the matching `fcw`.
- Back-to-back `pd_valid` is accepted every cycle; throughput is 1 sample/cycle.
- `int_sat` updates with `int_acc` at edge E.

## Structure
- Shared package `cdr_pkg`:
  - `loop_state_t` enum {ACQ, TRK}.
  - Signed error type (2-bit).
  - Default gain and width constants, shared with the phase detector and DCO.
- One natural sub-module, `cdr_lock_det`: run counter, good counter and the ACQ/TRK FSM. Its outputs are `locked` and a gain select.
- Datapath (decode, integrator, FCW sum/clamp) stays in `cdr_loop_filter`.

## Test plan
1. **Reset:** hold `rst_n=0` for 3 cycles, then release.
   - → `fcw=512`, `locked=0`, `fcw_valid=0`, `int_sat=0`.
2. **Up errors in ACQ:** 16 consecutive up strobes.
   - After the 1st: `fcw=528` (int 1>>>4=0, +16).
   - After the 16th: `fcw=529` (int=16).
   - `locked` stays 0; the run exceeds 8 at the 9th strobe.
3. **Lock and gear shift:** 64 alternating up/dn strobes.
   - `locked` rises at the edge sampling the 64th.
   - A following single up gives `fcw=512+0+4=516`.
   - Then 9 ups → `locked` falls on the 9th.
4. **Saturation** (override `KI=4096`): 8 up strobes.
   - → `int_acc=32767`, `int_sat=1`, `fcw=1023` (clamped).
   - Then 1 dn → `int_sat=0`.
5. **Null error:** `pd_up=pd_dn=1` strobe.
   - → `int_acc` unchanged, `fcw = center + int` (no KP term).
   - `fcw_valid` pulses; the run is unchanged and the good counter increments.
6. **Freeze and reset:** with `freeze=1`, send 10 up strobes.
   - → `fcw` held, no `fcw_valid` pulses.
   - Assert `rst_n=0` the cycle after a strobe → `fcw=512`, no `fcw_valid` pulse.
